// File: rtl/lut_frag_k.sv
// K-input LUT fragment with a serially loaded, double-buffered truth table,
// optional carry-in on the top select bit and a clock-enabled output register.
// Optional feature: LFRAG_CFG_PARITY_EN adds an even-parity bit to each configuration word.
module lut_frag_k #(
    parameter int K = 4
) (
    input  logic         QCK,
    input  logic         QRT,
    input  logic [K-1:0] I,
    input  logic         CarryIn,
    input  logic         QEN,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_data,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic         LUTOutput,
    output logic         CarryOut,
    output logic         QZ
);

    localparam int T  = 1 << K;
`ifdef LFRAG_CFG_PARITY_EN
    localparam int W  = T + 2;
`else
    localparam int W  = T + 1;
`endif
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   shadow;
    logic [W-1:0]   shadow_nxt;
    logic [T-1:0]   tbl;
    logic           cin_sel;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           last_bit;
    logic           word_ok;
    logic           msb;
    logic [K-1:0]   lut_idx;
    logic [K-1:0]   carry_idx;

    assign accept     = cfg_valid && cfg_ready;
    assign last_bit   = (cnt == CW'(W - 1));
    assign shadow_nxt = {cfg_data, shadow[W-1:1]};

    // Parity is judged on the word as it will stand after the final shift.
`ifdef LFRAG_CFG_PARITY_EN
    assign word_ok = ~^shadow_nxt;
`else
    assign word_ok = 1'b1;
`endif

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state     <= IDLE;
            shadow    <= '0;
            tbl       <= '0;
            cin_sel   <= 1'b0;
            cnt       <= '0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cfg_done <= 1'b0;
                    cfg_err  <= 1'b0;
                    if (cfg_start) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shadow <= shadow_nxt;
                        cnt    <= cnt + CW'(1);
                        if (last_bit) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                            cfg_done  <= word_ok;
                            cfg_err   <= !word_ok;
                        end
                    end
                end
                COMMIT: begin
                    // cfg_done doubles as the commit decision taken on the last shift.
                    if (cfg_done) begin
                        tbl     <= shadow[T-1:0];
                        cin_sel <= shadow[T];
                    end
                    cfg_done <= 1'b0;
                    cfg_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    cfg_done  <= 1'b0;
                    cfg_err   <= 1'b0;
                end
            endcase
        end
    end

    // Carry-out always reads the top half, whatever drives the top select.
    assign msb       = cin_sel ? CarryIn : I[K-1];
    assign lut_idx   = {msb, I[K-2:0]};
    assign carry_idx = {1'b1, I[K-2:0]};
    assign LUTOutput = tbl[lut_idx];
    assign CarryOut  = tbl[carry_idx];

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT)
            QZ <= 1'b0;
        else if (QEN)
            QZ <= LUTOutput;
    end

endmodule

// File: tb/tb_lut_frag_k.sv
// Randomised bench for lut_frag_k (K=4) against a word-level reference model,
// plus hand-computed checks for the load timing, carry path, abort and parity cases.
module tb_lut_frag_k;

    localparam int T = 16;
`ifdef LFRAG_CFG_PARITY_EN
    localparam int W = T + 2;
`else
    localparam int W = T + 1;
`endif

    logic       QCK = 1'b0;
    logic       QRT = 1'b1;
    logic [3:0] I = 4'hF;
    logic       CarryIn = 1'b0;
    logic       QEN = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_data = 1'b0;
    logic       cfg_ready, cfg_done, cfg_err, LUTOutput, CarryOut, QZ;

    int n_checks = 0;
    int n_err    = 0;
    bit rnd_en   = 1'b0;
    bit chk_en   = 1'b1;

    lut_frag_k #(.K(4)) dut (
        .QCK(QCK), .QRT(QRT), .I(I), .CarryIn(CarryIn), .QEN(QEN),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .LUTOutput(LUTOutput), .CarryOut(CarryOut), .QZ(QZ)
    );

    always #5 QCK = ~QCK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_lut(input logic [15:0] t, input logic c, input logic [3:0] i, input logic ci);
        int idx;
        idx = (c ? int'(ci) : int'(i[3])) * 8 + int'(i[2:0]);
        return t[idx];
    endfunction

    function automatic logic f_carry(input logic [15:0] t, input logic [3:0] i);
        return t[8 + int'(i[2:0])];
    endfunction

    logic [15:0] m_tbl = '0;
    logic        m_cin = 1'b0;
    logic        m_qz = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_commit = 1'b0;
    bit          m_ok = 1'b0;
    bit          m_bits[$];

    always @(posedge QCK) begin
        if (QRT) begin
            m_loading = 1'b0; m_commit = 1'b0; m_bits.delete();
            m_tbl = '0; m_cin = 1'b0; m_qz = 1'b0;
        end else begin
            if (QEN) m_qz = f_lut(m_tbl, m_cin, I, CarryIn);
            if (m_commit) begin
                if (m_ok) begin
                    for (int b = 0; b < T; b++) m_tbl[b] = m_bits[b];
                    m_cin = m_bits[T];
                end
                m_commit = 1'b0;
            end else if (m_loading) begin
                if (cfg_valid) begin
                    m_bits.push_back(cfg_data);
                    if (m_bits.size() == W) begin
                        int ones;
                        ones = 0;
                        foreach (m_bits[b]) ones += int'(m_bits[b]);
                        m_loading = 1'b0;
                        m_commit  = 1'b1;
`ifdef LFRAG_CFG_PARITY_EN
                        m_ok = (ones % 2) == 0;
`else
                        m_ok = 1'b1;
`endif
                    end
                end
            end else if (cfg_start) begin
                m_loading = 1'b1;
                m_bits.delete();
            end
        end
    end

    always @(negedge QCK) begin
        if (chk_en) begin
            if (QRT) begin
                chk("rst_ready", cfg_ready, 0);
                chk("rst_done", cfg_done, 0);
                chk("rst_lut", LUTOutput, 0);
                chk("rst_qz", QZ, 0);
            end else begin
                chk("ready", cfg_ready, m_loading);
                chk("done", cfg_done, m_commit && m_ok);
                chk("err", cfg_err, m_commit && !m_ok);
                chk("lut", LUTOutput, f_lut(m_tbl, m_cin, I, CarryIn));
                chk("carry", CarryOut, f_carry(m_tbl, I));
                chk("qz", QZ, m_qz);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge QCK); #1;
        if (rnd_en) begin
            I = 4'($urandom); CarryIn = 1'($urandom); QEN = 1'($urandom);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [15:0] t, input logic c);
        logic [W-1:0] w;
        w = '0;
        w[T:0] = {c, t};
`ifdef LFRAG_CFG_PARITY_EN
        w[T+1] = ^w[T:0];
`endif
        return w;
    endfunction

    task automatic start_load();
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi, input int gap);
        int  j;
        int  guard;
        logic rdy;
        j = lo; guard = 0;
        while (j <= hi && guard < 2000) begin
            rdy = cfg_ready;
            cfg_valid = ($urandom_range(99) >= gap);
            cfg_data = w[j];
            tick();
            if (cfg_valid && rdy) j++;
            guard++;
        end
        cfg_valid = 1'b0;
        if (j <= hi) chk("send_timeout", j, hi + 1);
    endtask

    task automatic finish_load(output logic got_done, output logic got_err);
        int g;
        g = 0;
        while (!(cfg_done || cfg_err) && g < 5) begin tick(); g++; end
        got_done = cfg_done; got_err = cfg_err;
        tick();
    endtask

    task automatic load(input logic [W-1:0] w, input int gap);
        logic d, e;
        start_load();
        send_bits(w, 0, W - 1, gap);
        finish_load(d, e);
    endtask

    initial begin
        logic [W-1:0] w;
        logic d, e;
        int cyc, j, done_cyc;

        // reset with all selects high
        tick(); tick();
        chk("reset_lut", LUTOutput, 0);
        chk("reset_carry", CarryOut, 0);
        chk("reset_qz", QZ, 0);
        chk("reset_ready", cfg_ready, 0);
        QRT = 1'b0;
        tick();

        // XOR4 with cfg_valid held high; count cycles to cfg_done
        QEN = 1'b1; I = 4'h0;
        w = mk(16'h6996, 1'b0);
        cfg_start = 1'b1; tick(); cfg_start = 1'b0;
        cyc = 1; j = 0; done_cyc = -1; cfg_valid = 1'b1;
        while (cyc < 40 && done_cyc < 0) begin
            if (cfg_done) done_cyc = cyc;
            else begin
                cfg_data = (j < W) ? w[j] : 1'b0;
                tick(); j++; cyc++;
            end
        end
        cfg_valid = 1'b0;
        chk("xor_done_cycle", done_cyc, W + 1);
        tick();
        chk("model_xor_tbl", m_tbl, 16'h6996);
        I = 4'b0111; #1 chk("xor_0111", LUTOutput, 1);
        I = 4'b0011; #1 chk("xor_0011", LUTOutput, 0);
        I = 4'b0111; tick();
        chk("xor_qz", QZ, 1);

        // carry path
        load(mk(16'hFF00, 1'b1), 0);
        I = 4'b0000; CarryIn = 1'b1;
        #1 chk("carry_lut_ci1", LUTOutput, 1);
        chk("carry_co_ci1", CarryOut, 1);
        CarryIn = 1'b0;
        #1 chk("carry_lut_ci0", LUTOutput, 0);
        chk("carry_co_ci0", CarryOut, 1);

        // double buffering with gaps
        rnd_en = 1'b1;
        load(mk(16'hFFFF, 1'b0), 20);
        start_load();
        send_bits(mk(16'h0000, 1'b0), 0, 9, 30);
        rnd_en = 1'b0; I = 4'h5; CarryIn = 1'b0;
        #1 chk("dbuf_mid", LUTOutput, 1);
        send_bits(mk(16'h0000, 1'b0), 10, W - 1, 30);
        chk("dbuf_commit_done", cfg_done, 1);
        chk("dbuf_commit_old", LUTOutput, 1);
        finish_load(d, e);
        #1 chk("dbuf_new", LUTOutput, 0);

        // random words, random gaps and inputs
        rnd_en = 1'b1;
        repeat (10) begin
            for (int b = 0; b < W; b++) w[b] = 1'($urandom);
            load(w, int'($urandom_range(50)));
            repeat (int'($urandom_range(4))) tick();
        end

        // abort after 7 accepted bits
        start_load();
        send_bits(mk(16'hFFFF, 1'b1), 0, 6, 0);
        rnd_en = 1'b0;
        QRT = 1'b1; I = 4'hF;
        #1 chk("abort_lut", LUTOutput, 0);
        chk("abort_ready", cfg_ready, 0);
        tick(); QRT = 1'b0;
        cfg_valid = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        chk("abort_idle_ready", cfg_ready, 0);
        chk("abort_tbl_lut", LUTOutput, 0);
        chk("abort_tbl_carry", CarryOut, 0);

`ifdef LFRAG_CFG_PARITY_EN
        load(mk(16'hFFFF, 1'b0), 0);
        w = '0; w[T:0] = {1'b0, 16'h0001};
        start_load();
        send_bits(w, 0, W - 1, 0);
        finish_load(d, e);
        chk("par_err", e, 1);
        chk("par_done", d, 0);
        I = 4'h0;
        #1 chk("par_retained", LUTOutput, 1);
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
